// File: rtl/sc_stream_decoder_if.sv
// Handshake and stream bundle between a controller and the stochastic stream decoder.
interface sc_stream_decoder_if #(
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic             abort;
    logic             sn_in;
    logic             sn_valid;
    logic             sel_out;
    logic             busy;
    logic             done;
    logic [LEN_W:0]   value;

    // Controller side: requests windows, supplies the bitstream, observes the result.
    modport master (
        output start,
        output abort,
        output sn_in,
        output sn_valid,
        input  sel_out,
        input  busy,
        input  done,
        input  value
    );

    // Decoder side.
    modport slave (
        input  start,
        input  abort,
        input  sn_in,
        input  sn_valid,
        output sel_out,
        output busy,
        output done,
        output value
    );
endinterface

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts ones over a 2^LEN_W-bit window and
// generates the alternating select stream that paces the sum stage.
module sc_stream_decoder #(
    parameter int unsigned LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sc_stream_decoder_if.slave   bus
);

    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   ones_q,    ones_d;
    logic [CNT_W-1:0]   value_q,   value_d;
    logic               sel_q,     sel_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    // Next-state, counter and output decode; everything holds unless a rule fires.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        value_d   = value_q;
        sel_d     = sel_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_ACCUM;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                    sel_d     = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                // Abort wins over a bit arriving in the same cycle.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.sn_valid) begin
                    ones_d    = ones_q + CNT_W'(bus.sn_in);
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    sel_d     = ~sel_q;
                    // All-ones bit counter marks the final bit; the counter wraps to 0.
                    if (&bit_cnt_q) begin
                        value_d = ones_d;
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACCUM);
        done_d = (state_d == ST_DONE);
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            value_q   <= '0;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            value_q   <= value_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sel_out = sel_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.value   = value_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder with a scoreboard of expected window results.
module tb_sc_stream_decoder;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned N     = 16;

    logic clk = 1'b0;
    logic rst;

    sc_stream_decoder_if #(.LEN_W(LEN_W)) bus ();

    sc_stream_decoder #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [LEN_W:0] sb_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One full window; gap_mask/start_mask are indexed by slot count after the start slot.
    // With chain=1 the task returns in the DONE cycle with start already raised.
    task automatic run_window(input logic [15:0] pat, input logic [63:0] gap_mask,
                              input logic [63:0] start_mask, input bit chain);
        int acc  = 0;
        int t    = 0;
        int gaps = 0;
        logic [LEN_W:0] exp_v;
        sb_q.push_back((LEN_W+1)'($countones(pat)));
        bus.start    = 1'b1;
        bus.sn_valid = 1'b0;
        step();
        t = 1;
        while (acc < int'(N) && t < 64) begin
            check("busy_accum", bus.busy, 1);
            check("sel_phase", bus.sel_out, 32'(acc % 2));
            check("done_low", bus.done, 0);
            bus.start    = start_mask[t];
            bus.sn_valid = !gap_mask[t];
            bus.sn_in    = bus.sn_valid ? pat[acc] : 1'($urandom);
            if (bus.sn_valid) acc++;
            else gaps++;
            step();
            t++;
        end
        check("window_accepted", acc, N);
        bus.sn_valid = 1'b0;
        bus.start    = chain;
        check("done_pulse", bus.done, 1);
        check("busy_done", bus.busy, 0);
        check("sel_end", bus.sel_out, 0);
        check("done_latency", t, 32'(17 + gaps));
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            check("value", bus.value, exp_v);
        end
        if (!chain) begin
            step();
            check("done_one_cycle", bus.done, 0);
            check("idle_busy", bus.busy, 0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.sn_in    = 1'b0;
        bus.sn_valid = 1'b0;
        step();
        step();
        check("rst_sel", bus.sel_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_value", bus.value, 0);
        rst = 1'b0;
        step();

        // All ones, all zeros, alternating.
        run_window(16'hFFFF, 64'h0, 64'h0, 1'b0);
        run_window(16'h0000, 64'h0, 64'h0, 1'b0);
        run_window(16'h5555, 64'h0, 64'h0, 1'b0);

        // Three ones with five scattered invalid cycles.
        run_window(16'h0421, (64'h1 << 2) | (64'h1 << 5) | (64'h1 << 9) | (64'h1 << 13) | (64'h1 << 17),
                   64'h0, 1'b0);

        // Start pulses while busy are ignored; start in DONE chains the next window.
        run_window(16'h0F0F, 64'h0, (64'h1 << 3) | (64'h1 << 8) | (64'h1 << 12) | (64'h1 << 16), 1'b1);
        run_window(16'h5555, 64'h0, 64'h0, 1'b0);

        // Abort after seven accepted ones, with a valid bit offered in the abort cycle.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("abort_pre_busy", bus.busy, 1);
            bus.sn_valid = 1'b1;
            bus.sn_in    = 1'b1;
            step();
        end
        bus.abort    = 1'b1;
        bus.sn_valid = 1'b1;
        bus.sn_in    = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.sn_valid = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_value", bus.value, 8);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_quiet_done", bus.done, 0);
            check("abort_hold_value", bus.value, 8);
        end

        // Abort while idle is ignored and start still launches a window.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("idle_abort_ignored", bus.busy, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_again_busy", bus.busy, 0);
        check("abort_again_value", bus.value, 8);

        // Reset mid-window after ten bits of a run following a full-count result.
        run_window(16'hFFFF, 64'h0, 64'h0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.sn_valid = 1'b1;
            bus.sn_in    = 1'b1;
            step();
        end
        check("pre_rst_value", bus.value, 16);
        rst          = 1'b1;
        bus.sn_valid = 1'b1;
        bus.sn_in    = 1'b1;
        step();
        rst          = 1'b0;
        bus.sn_valid = 1'b0;
        check("mid_rst_value", bus.value, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_sel", bus.sel_out, 0);
        check("mid_rst_done", bus.done, 0);
        step();
        check("post_rst_idle", bus.busy, 0);
        run_window(16'hFFFF, 64'h0, 64'h0, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Stochastic-to-binary converter for the deterministic SC MAC datapath. Counts the ones in a fixed-length stochastic bitstream, typically the registered output of the stochastic sum stage, and returns the binary count with a start/busy/done handshake. It also generates the 50% select stream that drives the sum stage's `sel` input, so one block both paces and decodes an addition window.

## Interface
Parameters:
- `LEN_W`, default 8: log2 of the stream length. The window is N = 2^LEN_W accepted bits.

Ports:
- `clk`  in  1: single clock; all logic updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a decode window. Sampled only when `busy`=0.
- `abort`  in  1: cancel the current window. Sampled only when `busy`=1.
- `sn_in`  in  1: stochastic bitstream input.
- `sn_valid`  in  1: `sn_in` is a valid bit this cycle.
- `sel_out`  out  1: select stream for the sum stage.
- `busy`  out  1: window in progress.
- `done`  out  1: one-cycle pulse when `value` is updated.
- `value`  out  LEN_W+1: count of ones in the last completed window, range 0..N.

## Operation
- States: IDLE, ACCUM, DONE. The reset state is IDLE.
- IDLE, or DONE, with `start`=1:
  - Clear the bit counter (LEN_W bits) and the ones counter (LEN_W+1 bits).
  - Clear `sel_out`.
  - Go to ACCUM.
- IDLE or DONE with `start`=0: go to IDLE. DONE lasts exactly one cycle.
- ACCUM:
  - A bit is accepted on each cycle with `sn_valid`=1.
  - On acceptance: ones += `sn_in`, bit counter += 1, `sel_out` toggles.
  - With `sn_valid`=0, all state holds.
- Window end: the cycle that accepts a bit while the bit counter = N-1.
  - `value` <= ones + `sn_in`.
  - Go to DONE.
  - The bit counter wraps to 0. This is harmless.
- ACCUM with `abort`=1 (abort has priority over acceptance):
  - Go to IDLE.
  - `value` is unchanged and no `done` pulse is issued.
- `start` while `busy`=1 is ignored.
- `abort` while `busy`=0 is ignored.
- The ones counter needs LEN_W+1 bits to hold N without overflow. It never saturates or wraps.
- Outputs per state: `busy`=1 only in ACCUM; `done`=1 only in DONE.
- `value` holds its last result until the next window end or `rst`.
- Reset values: `sel_out`=0, `busy`=0, `done`=0, `value`=0; internal counters are 0.
- `rst` mid-window discards the partial count and returns to IDLE.

## Timing
- `start` sampled at edge k: `busy`=1 from cycle k+1. The first bit can be accepted at the edge ending cycle k+1.
- With `sn_valid` continuously 1, bits are accepted at edges k+1..k+N.
  - `done`=1 and the new `value` are visible during cycle k+N+1.
  - `busy`=0 in that same cycle.
- Each `sn_valid`=0 cycle inside ACCUM delays `done` by one cycle.
- Back-to-back windows: `start`=1 during the DONE cycle begins the next window. This gives one idle cycle between windows (`busy` low only in the DONE cycle).
- `sel_out` is registered. Bit j of the window (j from 0) is accepted while `sel_out` = j mod 2.
  - The sum stage's registered output therefore lines up one cycle later. The integrator compensates by delaying `sn_in`; this block does not.
- `abort` sampled at edge m: `busy`=0 from cycle m+1.
- `rst` sampled at edge m: all outputs are at reset values in cycle m+1, whatever the state.

## Test plan
All scenarios use LEN_W=4 (N=16).
- `start`, then 16 cycles of `sn_valid`=1, `sn_in`=1 -> `done` pulse exactly 17 cycles after `start`, `value`=16, `busy` high for 16 cycles.
- All-zero stream -> `value`=0. Then the alternating stream 1,0,1,0,… -> `value`=8. `sel_out` toggles 16 times and is 0 again at `done`.
- `sn_valid` low for 5 scattered cycles, stream pattern 3 ones in 16 accepted bits -> `value`=3, `done` 22 cycles after `start`.
- `start` pulsed repeatedly while `busy` -> ignored, result unchanged. `start` during the DONE cycle -> second window begins; `busy` low for exactly one cycle.
- `abort` after 7 accepted ones -> `busy` falls next cycle, no `done`, `value` keeps its prior value of 8.
- `rst` after 10 accepted bits of a previous `value`=16 run -> `value`=0, `busy`=0, `sel_out`=0 next cycle. A fresh window of all ones then yields 16.
